gpr_file_mp: RTL and testbench
==============================

# gpr_file_mp

Parametrised multi-port general-purpose register file for the RV32IM core, successor to the two-read/one-write GPR array. Adds configurable width, depth and port counts, a second write port for long-latency results (MUL/DIV unit, encryption accelerator), same-cycle write-to-read bypass, and a per-register pending-write scoreboard. It sits between decode (reads, claims) and writeback (commits), and provides busy flags that the hazard unit uses to stall.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of registers; power of two, ≥ 2; register 0 is hardwired zero
- NREAD, 2, number of read ports
- NWRITE, 2, number of write ports; port NWRITE-1 is the long-latency port
- BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read returns array contents only

Ports (AW = log2(NREGS)):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- read_add  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
- data_read  out  NREAD*XLEN  read data, port i at [i*XLEN +: XLEN]
- read_busy  out  NREAD  1 = addressed register has a pending long-latency write
- write_en  in  NWRITE  per-port write enable
- rd_add  in  NWRITE*AW  per-port destination address
- data_write  in  NWRITE*XLEN  per-port write data
- claim_en  in  1  mark rd as pending (long-latency op issued)
- claim_add  in  AW  register to mark pending
- busy_vec  out  NREGS  scoreboard state; bit 0 always 0

## Operation
- Array: NREGS × XLEN flops. Register 0 reads 0 and ignores all writes and claims.
- Write: on a rising edge with write_en[p]=1 and rd_add[p]≠0, reg[rd_add[p]] ← data_write[p].
- Write collision (two ports, same address, same cycle): the highest-numbered port wins; the other write is dropped.
- Read: combinational. If BYPASS=1 and any enabled write port targets the read address (≠0), data_read returns that port's data; highest-numbered port wins on collision. Otherwise it returns the array value. Address 0 always returns 0.
- Scoreboard: busy[r] is set on an edge with claim_en=1 and claim_add=r≠0. It is cleared on an edge where write port NWRITE-1 writes r. Writes from other ports do not clear busy.
- Simultaneous claim and clear of the same register: claim wins, so busy stays 1. This case is a back-to-back long-latency op to the same rd.
- Claim of an already-busy register: busy stays 1. No error is flagged; the hazard unit prevents this case.
- read_busy[i] = busy[read_add[i]]. If BYPASS=1 and port NWRITE-1 is writing that address this cycle without a same-cycle claim, read_busy[i]=0. This lets a dependent instruction issue in the writeback cycle.

## Timing
- Read latency 0 (combinational). Write and scoreboard latency is 1 edge.
- Reset (rst=1 at an edge): all registers 0 and all busy 0. Writes and claims in the reset cycle are ignored. Reset asserted mid-operation discards pending state without any drain.
- After reset: data_read = 0, read_busy = 0, busy_vec = 0 for all ports.
- With BYPASS=0, a read of a register being written in the same cycle returns the old value, and the new value is visible from the next cycle.
- No handshake on write ports. The producer guarantees that write data is valid while write_en is high.

## Structure
- Package gpr_pkg holds:
  - function clog2 and the AW derivation;
  - localparam ZERO_REG = 0;
  - typedef gpr_addr_t (AW bits) and gpr_data_t (XLEN bits) for the default configuration.
- Sub-module gpr_scoreboard (NREGS, AW):
  - inputs: clk, rst, claim_en, claim_add, clear_en, clear_add;
  - output: busy_vec;
  - implements the set/clear priority rules.
- The top level contains the array, the write-priority logic and the per-port bypass mux, generated over NREAD and NWRITE.

## Test plan
- Reset then read: hold rst=1 for 2 cycles, then release. Read x0, x5 and x31 → all return 0; busy_vec = 0.
- Write then read: write 0xABCDEF01 to x3 via port 0. In the same cycle, read_add = 3 → data_read = 0xABCDEF01 (BYPASS=1) or 0 (BYPASS=0). The next cycle → 0xABCDEF01 in both modes.
- x0 protection: write 0xFFFFFFFF to x0 on both ports and claim x0 → data_read(x0) = 0 and busy_vec[0] = 0.
- Collision: port 0 writes 0x11111111 and port 1 writes 0x22222222 to x7 in the same cycle → x7 = 0x22222222. The bypass also returns 0x22222222.
- Scoreboard, basic: claim x9 → read_busy = 1 on the next cycle. A port 0 write to x9 leaves busy = 1. A port 1 write of 0x1234 to x9 gives read_busy = 0 in the same cycle (BYPASS=1) and data 0x1234.
- Scoreboard, edge cases: claim x9 in the same cycle as a port 1 write to x9 → busy stays 1. Assert rst mid-pending → busy_vec = 0 and x9 = 0.

Source files
------------

// File: rtl/gpr_pkg.sv
// gpr_pkg
// Shared definitions for the multi-port GPR file: address-width helper,
// the hardwired-zero register index, and address/data types for the default
// RV32 configuration (32 x 32-bit).
package gpr_pkg;

    function automatic int clog2(input int value);
        int result;
        for (result = 0; (1 << result) < value; result++) begin
        end
        return result;
    endfunction

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = clog2(NREGS_DEF);

    localparam int ZERO_REG = 0;

    typedef logic [AW_DEF-1:0]   gpr_addr_t;
    typedef logic [XLEN_DEF-1:0] gpr_data_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard
// Per-register pending-write flags for long-latency results.
//   clk, rst            clock, synchronous active-high reset
//   claim_en, claim_add mark a register pending (long-latency op issued)
//   clear_en, clear_add long-latency writeback completing for a register
//   busy_vec            one flag per register; bit 0 is always 0
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             claim_en,
    input  logic [AW-1:0]    claim_add,
    input  logic             clear_en,
    input  logic [AW-1:0]    clear_add,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Claim is applied after clear so a back-to-back long-latency op to the
    // same rd keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        if (clear_en) begin
            busy_d[clear_add] = 1'b0;
        end
        if (claim_en) begin
            busy_d[claim_add] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/gpr_file_mp.sv
// gpr_file_mp
// Multi-port general-purpose register file with write bypass and a
// pending-write scoreboard. Register 0 is hardwired to zero.
//   clk, rst    clock, synchronous active-high reset
//   read_add    NREAD packed read addresses
//   data_read   NREAD packed read data (combinational)
//   read_busy   per read port: addressed register awaits a long-latency write
//   write_en    per write port enable; port NWRITE-1 is the long-latency port
//   rd_add      per write port destination address
//   data_write  per write port data
//   claim_en    mark claim_add as pending
//   claim_add   register to mark pending
//   busy_vec    scoreboard state
module gpr_file_mp
    import gpr_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    parameter int BYPASS = 1,
    localparam int AW    = clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*AW-1:0]    read_add,
    output logic [NREAD*XLEN-1:0]  data_read,
    output logic [NREAD-1:0]       read_busy,
    input  logic [NWRITE-1:0]      write_en,
    input  logic [NWRITE*AW-1:0]   rd_add,
    input  logic [NWRITE*XLEN-1:0] data_write,
    input  logic                   claim_en,
    input  logic [AW-1:0]          claim_add,
    output logic [NREGS-1:0]       busy_vec
);

    localparam int LP = NWRITE - 1;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Ports are applied in ascending order so the highest-numbered port
    // overwrites any lower port targeting the same register.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NWRITE; p++) begin
            if (write_en[p]) begin
                regs_d[rd_add[p*AW +: AW]] = data_write[p*XLEN +: XLEN];
            end
        end
        regs_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    gpr_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .claim_en  (claim_en),
        .claim_add (claim_add),
        .clear_en  (write_en[LP]),
        .clear_add (rd_add[LP*AW +: AW]),
        .busy_vec  (busy_vec)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rdata;
        logic            rbusy;

        assign addr = read_add[i*AW +: AW];

        always_comb begin
            rdata = regs_q[addr];
            if (BYPASS != 0) begin
                for (int p = 0; p < NWRITE; p++) begin
                    if (write_en[p] && (rd_add[p*AW +: AW] == addr)) begin
                        rdata = data_write[p*XLEN +: XLEN];
                    end
                end
            end
            if (addr == AW'(ZERO_REG)) begin
                rdata = '0;
            end
        end

        // A completing long-latency write releases the dependent reader in
        // the same cycle, unless a new claim re-arms that register.
        always_comb begin
            rbusy = busy_vec[addr];
            if ((BYPASS != 0) && write_en[LP] && (rd_add[LP*AW +: AW] == addr) &&
                !(claim_en && (claim_add == addr))) begin
                rbusy = 1'b0;
            end
        end

        assign data_read[i*XLEN +: XLEN] = rdata;
        assign read_busy[i]              = rbusy;
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
module tb_gpr_file_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = 5;

    logic                   clk;
    logic                   rst;
    logic [NREAD*AW-1:0]    read_add;
    logic [NREAD*XLEN-1:0]  data_read;
    logic [NREAD-1:0]       read_busy;
    logic [NWRITE-1:0]      write_en;
    logic [NWRITE*AW-1:0]   rd_add;
    logic [NWRITE*XLEN-1:0] data_write;
    logic                   claim_en;
    logic [AW-1:0]          claim_add;
    logic [NREGS-1:0]       busy_vec;

    int total = 0;
    int bad   = 0;

    // Reference state: register contents and pending flags.
    logic [31:0] m_regs [NREGS];
    bit          m_busy [NREGS];

    gpr_file_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .NWRITE (NWRITE),
        .BYPASS (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .read_add   (read_add),
        .data_read  (data_read),
        .read_busy  (read_busy),
        .write_en   (write_en),
        .rd_add     (rd_add),
        .data_write (data_write),
        .claim_en   (claim_en),
        .claim_add  (claim_add),
        .busy_vec   (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_reads(input int a0, input int a1);
        read_add[0 +: AW]  = AW'(a0);
        read_add[AW +: AW] = AW'(a1);
    endtask

    task automatic set_write(input int p, input bit en, input int addr, input logic [31:0] d);
        write_en[p]            = en;
        rd_add[p*AW +: AW]     = AW'(addr);
        data_write[p*32 +: 32] = d;
    endtask

    task automatic idle_inputs();
        write_en   = '0;
        rd_add     = '0;
        data_write = '0;
        claim_en   = 1'b0;
        claim_add  = '0;
    endtask

    // Compare all outputs with what the register-file rules predict from the
    // reference state and the inputs currently applied.
    task automatic check_model();
        int          a;
        logic [31:0] ed;
        logic        eb;
        logic [31:0] ev;
        for (int i = 0; i < NREAD; i++) begin
            a  = int'(read_add[i*AW +: AW]);
            ed = (a == 0) ? 32'h0 : m_regs[a];
            eb = (a != 0) && m_busy[a];
            if (a != 0) begin
                for (int p = 0; p < NWRITE; p++) begin
                    if (write_en[p] && int'(rd_add[p*AW +: AW]) == a) ed = data_write[p*32 +: 32];
                end
                if (write_en[NWRITE-1] && int'(rd_add[(NWRITE-1)*AW +: AW]) == a &&
                    !(claim_en && int'(claim_add) == a)) eb = 1'b0;
            end
            chk($sformatf("model_data_p%0d_x%0d", i, a), data_read[i*32 +: 32], ed);
            chk($sformatf("model_busy_p%0d_x%0d", i, a), {31'b0, read_busy[i]}, {31'b0, eb});
        end
        ev = '0;
        for (int r = 0; r < NREGS; r++) ev[r] = m_busy[r];
        chk("model_busy_vec", busy_vec, ev);
    endtask

    task automatic update_model();
        int wa;
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] = 32'h0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int p = 0; p < NWRITE; p++) begin
                wa = int'(rd_add[p*AW +: AW]);
                if (write_en[p] && wa != 0) m_regs[wa] = data_write[p*32 +: 32];
            end
            wa = int'(rd_add[(NWRITE-1)*AW +: AW]);
            if (write_en[NWRITE-1] && wa != 0) m_busy[wa] = 1'b0;
            if (claim_en && claim_add != 0) m_busy[int'(claim_add)] = 1'b1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic clock_edge();
        @(posedge clk);
        update_model();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        read_add = '0;
        idle_inputs();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = 32'hx;
            m_busy[r] = 1'b0;
        end

        // Reset held two cycles, with a write and claim that must be ignored.
        set_write(0, 1'b1, 4, 32'hDEADBEEF);
        claim_en = 1'b1; claim_add = 5'd4;
        clock_edge();
        clock_edge();
        rst = 1'b0;
        idle_inputs();

        set_reads(0, 5);
        settle();
        chk("reset_x0", data_read[31:0], 32'h0);
        chk("reset_x5", data_read[63:32], 32'h0);
        chk("reset_busy_vec", busy_vec, 32'h0);
        clock_edge();
        set_reads(31, 4);
        settle();
        chk("reset_x31", data_read[31:0], 32'h0);
        chk("reset_x4_ignored", data_read[63:32], 32'h0);
        clock_edge();

        // Write x3 on port 0: bypassed same cycle, stored next cycle.
        set_write(0, 1'b1, 3, 32'hABCDEF01);
        set_reads(3, 0);
        settle();
        chk("wr_bypass_x3", data_read[31:0], 32'hABCDEF01);
        clock_edge();
        idle_inputs();
        settle();
        chk("wr_stored_x3", data_read[31:0], 32'hABCDEF01);
        clock_edge();

        // x0 protection.
        set_write(0, 1'b1, 0, 32'hFFFFFFFF);
        set_write(1, 1'b1, 0, 32'hFFFFFFFF);
        claim_en = 1'b1; claim_add = 5'd0;
        set_reads(0, 0);
        settle();
        chk("x0_bypass", data_read[31:0], 32'h0);
        clock_edge();
        idle_inputs();
        settle();
        chk("x0_stored", data_read[63:32], 32'h0);
        chk("x0_busy", {31'b0, busy_vec[0]}, 32'h0);
        clock_edge();

        // Collision on x7: port 1 wins.
        set_write(0, 1'b1, 7, 32'h11111111);
        set_write(1, 1'b1, 7, 32'h22222222);
        set_reads(7, 3);
        settle();
        chk("coll_bypass_x7", data_read[31:0], 32'h22222222);
        clock_edge();
        idle_inputs();
        settle();
        chk("coll_stored_x7", data_read[31:0], 32'h22222222);
        clock_edge();

        // Scoreboard basic.
        claim_en = 1'b1; claim_add = 5'd9;
        set_reads(9, 7);
        settle();
        clock_edge();
        idle_inputs();
        settle();
        chk("sb_claim_busy", {31'b0, read_busy[0]}, 32'h1);
        clock_edge();
        set_write(0, 1'b1, 9, 32'h00000055);
        settle();
        chk("sb_p0_no_release", {31'b0, read_busy[0]}, 32'h1);
        clock_edge();
        idle_inputs();
        settle();
        chk("sb_p0_still_busy", {31'b0, busy_vec[9]}, 32'h1);
        clock_edge();
        set_write(1, 1'b1, 9, 32'h00001234);
        settle();
        chk("sb_p1_release_busy", {31'b0, read_busy[0]}, 32'h0);
        chk("sb_p1_release_data", data_read[31:0], 32'h00001234);
        clock_edge();
        idle_inputs();
        settle();
        chk("sb_cleared", {31'b0, busy_vec[9]}, 32'h0);
        clock_edge();

        // Claim wins over a simultaneous clear.
        claim_en = 1'b1; claim_add = 5'd9;
        settle();
        clock_edge();
        set_write(1, 1'b1, 9, 32'h00000777);
        settle();
        chk("sb_claim_clear_read_busy", {31'b0, read_busy[0]}, 32'h1);
        clock_edge();
        idle_inputs();
        settle();
        chk("sb_claim_wins", {31'b0, busy_vec[9]}, 32'h1);
        clock_edge();

        // Reset while pending.
        rst = 1'b1;
        settle();
        clock_edge();
        rst = 1'b0;
        settle();
        chk("mid_rst_busy_vec", busy_vec, 32'h0);
        chk("mid_rst_x9", data_read[31:0], 32'h0);
        clock_edge();

        // Randomised traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_reads($urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            for (int p = 0; p < NWRITE; p++) begin
                set_write(p, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom());
            end
            claim_en  = ($urandom_range(0, 2) == 0);
            claim_add = AW'($urandom_range(0, 7));
            settle();
            clock_edge();
        end
        rst = 1'b0;
        idle_inputs();
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
